// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus for pc_sequencer.
// The sequencer drives the request and address; memory returns a one-cycle ack
// once the instruction at imem_addr is available.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and sequences IDLE -> FETCH -> ISSUE.
// FETCH holds imem_req/imem_addr until imem_ack. ISSUE presents the slot to decode,
// holding it while stall is high. On an ISSUE exit the next pc is the branch
// target (PCSrc), else the jump target (jump), else pc+4. Redirect targets are
// word-aligned on load. A redirect produces a one-cycle registered flush.
// Every output is decoded from registered state, so none of them depends
// combinationally on an input.
// Optional build macro BRANCH_STATS_EN adds saturating instr/taken/jump counters.
module pc_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    pc_sequencer_if.master      imem,
    input  logic                PCSrc,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic                jump,
    input  logic [ADDR_W-1:0]   jump_target,
    input  logic                stall,
    output logic                instr_valid,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus4,
`ifdef BRANCH_STATS_EN
    output logic [31:0]         instr_cnt,
    output logic [31:0]         taken_cnt,
    output logic [31:0]         jump_cnt,
`endif
    output logic                flush
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;

    // Clear the two low address bits of a redirect target.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] t);
        return t & ~{{(ADDR_W-2){1'b0}}, 2'b11};
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [1:0]        state_p0;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] pc_p0;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pc_inc;
    logic              flush_p0;
    logic              redirect;
    logic              issue_exit;

    assign pc_inc = pc_p0 + ADDR_W'(4);

    // Next-state and next-pc selection; redirect priority is branch, then jump, then sequential.
    always_comb begin
        state_nxt  = state_p0;
        pc_nxt     = pc_p0;
        redirect   = 1'b0;
        issue_exit = 1'b0;
        case (state_p0)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (imem.imem_ack) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    issue_exit = 1'b1;
                    state_nxt  = FETCH;
                    if (PCSrc) begin
                        redirect = 1'b1;
                        pc_nxt   = align_word(branch_target);
                    end else if (jump) begin
                        redirect = 1'b1;
                        pc_nxt   = align_word(jump_target);
                    end else begin
                        pc_nxt   = pc_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // --- stage p0: state, pc and flush registers ---
    // Asynchronous reset so imem_req drops as soon as rst rises, even mid-fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= IDLE;
            pc_p0    <= RESET_PC;
            flush_p0 <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            pc_p0    <= pc_nxt;
            flush_p0 <= redirect;
        end
    end

    assign imem.imem_req  = (state_p0 == FETCH);
    assign imem.imem_addr = pc_p0;
    assign instr_valid    = (state_p0 == ISSUE);
    assign pc             = pc_p0;
    assign pc_plus4       = pc_inc;
    assign flush          = flush_p0;

`ifdef BRANCH_STATS_EN
    logic [31:0] instr_cnt_p0;
    logic [31:0] taken_cnt_p0;
    logic [31:0] jump_cnt_p0;

    // Count ISSUE exits by kind; a simultaneous branch and jump counts as a taken branch only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_p0 <= 32'd0;
            taken_cnt_p0 <= 32'd0;
            jump_cnt_p0  <= 32'd0;
        end else if (issue_exit) begin
            instr_cnt_p0 <= sat_inc(instr_cnt_p0);
            if (PCSrc) begin
                taken_cnt_p0 <= sat_inc(taken_cnt_p0);
            end else if (jump) begin
                jump_cnt_p0  <= sat_inc(jump_cnt_p0);
            end
        end
    end

    assign instr_cnt = instr_cnt_p0;
    assign taken_cnt = taken_cnt_p0;
    assign jump_cnt  = jump_cnt_p0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (RESET_PC = 0x100). Inputs change on the
// falling edge and outputs are sampled there too.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        PCSrc;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        stall;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
`ifdef BRANCH_STATS_EN
    logic [31:0] instr_cnt;
    logic [31:0] taken_cnt;
    logic [31:0] jump_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (bus),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .stall         (stall),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
`ifdef BRANCH_STATS_EN
        .instr_cnt     (instr_cnt),
        .taken_cnt     (taken_cnt),
        .jump_cnt      (jump_cnt),
`endif
        .flush         (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive-only helpers: return ack from memory, and leave ISSUE with the given redirect inputs.
    task automatic ack_to_issue();
        bus.imem_ack = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
    endtask

    task automatic issue_exit(input logic b, input logic [31:0] bt, input logic j, input logic [31:0] jt);
        PCSrc = b; branch_target = bt; jump = j; jump_target = jt; stall = 1'b0;
        @(negedge clk);
        PCSrc = 1'b0; jump = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flush); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h expected 00000100", pc); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL reset_exit_req: got %b expected 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL reset_exit_addr: got %h expected 00000100", bus.imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        for (int i = 0; i < 3; i++) begin
            exp = 32'h100 + 32'(4 * i);
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp) begin errors++; $display("FAIL seq_fetch[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, bus.imem_req, bus.imem_addr, exp); end
            ack_to_issue();
            checks++; if (instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || pc !== exp) begin errors++; $display("FAIL seq_issue[%0d]: got valid=%b req=%b pc=%h expected 1 0 %h", i, instr_valid, bus.imem_req, pc, exp); end
            checks++; if (flush !== 1'b0) begin errors++; $display("FAIL seq_flush_issue[%0d]: got %b expected 0", i, flush); end
            issue_exit(1'b0, 32'h0, 1'b0, 32'h0);
            checks++; if (flush !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL seq_after[%0d]: got flush=%b valid=%b expected 0 0", i, flush, instr_valid); end
        end
    endtask

    task automatic test_branch_vs_jump();
        ack_to_issue();
        issue_exit(1'b0, 32'h0, 1'b1, 32'h200);
        checks++; if (bus.imem_addr !== 32'h200 || flush !== 1'b1) begin errors++; $display("FAIL jump_redirect: got addr=%h flush=%b expected 00000200 1", bus.imem_addr, flush); end
        ack_to_issue();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL bvj_issue_pc: got %h expected 00000200", pc); end
        issue_exit(1'b1, 32'h403, 1'b1, 32'h800);
        checks++; if (bus.imem_addr !== 32'h400) begin errors++; $display("FAIL bvj_addr: got %h expected 00000400", bus.imem_addr); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL bvj_flush_on: got %b expected 1", flush); end
        @(negedge clk);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL bvj_flush_off: got %b expected 0", flush); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h400) begin errors++; $display("FAIL bvj_hold: got req=%b addr=%h expected 1 00000400", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_stall();
        ack_to_issue();
        stall = 1'b1; branch_target = 32'h900; PCSrc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (pc !== 32'h400 || instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d]: got pc=%h valid=%b req=%b flush=%b expected 00000400 1 0 0", i, pc, instr_valid, bus.imem_req, flush); end
            PCSrc = ~PCSrc;
        end
        issue_exit(1'b0, 32'h900, 1'b0, 32'h0);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h404 || flush !== 1'b0) begin errors++; $display("FAIL stall_release: got req=%b addr=%h flush=%b expected 1 00000404 0", bus.imem_req, bus.imem_addr, flush); end
    endtask

    task automatic test_ack_delay_wrap();
        ack_to_issue();
        issue_exit(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin errors++; $display("FAIL ack_wait[%0d]: got req=%b addr=%h valid=%b expected 1 fffffffc 0", i, bus.imem_req, bus.imem_addr, instr_valid); end
            @(negedge clk);
        end
        ack_to_issue();
        checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_issue: got pc=%h pc_plus4=%h expected fffffffc 00000000", pc, pc_plus4); end
        issue_exit(1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (bus.imem_addr !== 32'h0 || flush !== 1'b0) begin errors++; $display("FAIL wrap_next: got addr=%h flush=%b expected 00000000 0", bus.imem_addr, flush); end
    endtask

    task automatic test_reset_midfetch();
        ack_to_issue();
        issue_exit(1'b0, 32'h0, 1'b1, 32'h300);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) begin errors++; $display("FAIL midfetch_pre: got req=%b addr=%h expected 1 00000300", bus.imem_req, bus.imem_addr); end
        rst = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL midfetch_req_drop: got %b expected 0", bus.imem_req); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL midfetch_pc: got %h expected 00000100", pc); end
        @(negedge clk);
        rst = 1'b0;
        bus.imem_ack = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL midfetch_idle: got req=%b valid=%b expected 0 0", bus.imem_req, instr_valid); end
        @(negedge clk);
        bus.imem_ack = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || instr_valid !== 1'b0) begin errors++; $display("FAIL midfetch_refetch: got req=%b addr=%h valid=%b expected 1 00000100 0", bus.imem_req, bus.imem_addr, instr_valid); end
        ack_to_issue();
        checks++; if (instr_valid !== 1'b1 || pc !== 32'h100) begin errors++; $display("FAIL midfetch_issue: got valid=%b pc=%h expected 1 00000100", instr_valid, pc); end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_branch_stats();
        issue_exit(1'b0, 32'h0, 1'b0, 32'h0);
        ack_to_issue();
        issue_exit(1'b1, 32'h500, 1'b0, 32'h0);
        ack_to_issue();
        stall = 1'b1; PCSrc = 1'b1;
        @(negedge clk);
        issue_exit(1'b0, 32'h0, 1'b1, 32'h600);
        ack_to_issue();
        issue_exit(1'b1, 32'h700, 1'b1, 32'h800);
        ack_to_issue();
        issue_exit(1'b0, 32'h0, 1'b0, 32'h0);
        checks++; if (instr_cnt !== 32'd5) begin errors++; $display("FAIL stats_instr: got %0d expected 5", instr_cnt); end
        checks++; if (taken_cnt !== 32'd2) begin errors++; $display("FAIL stats_taken: got %0d expected 2", taken_cnt); end
        checks++; if (jump_cnt !== 32'd1) begin errors++; $display("FAIL stats_jump: got %0d expected 1", jump_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        PCSrc = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0;
        stall = 1'b0;
        bus.imem_ack = 1'b0;
        test_reset();
        test_sequential();
        test_branch_vs_jump();
        test_stall();
        test_ack_delay_wrap();
        test_reset_midfetch();
`ifdef BRANCH_STATS_EN
        test_branch_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumer end of the branch-decision path: takes PCSrc from the branch control logic, plus the branch/jump targets, and owns the program counter.
- Sequences instruction fetch through a req/ack handshake to instruction memory.
- Presents a valid instruction slot to decode, honouring stall.
- Generates a one-cycle flush on every redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).
- ADDR_W, 32, PC/address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- PCSrc  input  1  branch taken, from branch control; valid in ISSUE.
- branch_target  input  ADDR_W  branch destination.
- jump  input  1  unconditional jump request; valid in ISSUE.
- jump_target  input  ADDR_W  jump destination.
- stall  input  1  decode cannot accept; hold the current slot.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  ADDR_W  fetch address; equals pc.
- imem_ack  input  1  memory has returned the instruction at imem_addr.
- instr_valid  output  1  current slot holds a fetched instruction.
- pc  output  ADDR_W  address of the current instruction.
- pc_plus4  output  ADDR_W  pc + 4, modulo 2^ADDR_W.
- flush  output  1  one-cycle pulse on redirect.

Behaviour:
- Reset (async, while rst=1):
  - pc=RESET_PC; state=IDLE.
  - imem_req=0, instr_valid=0, flush=0.
  - Reset asserted mid-fetch drops imem_req immediately. Any later imem_ack is ignored until FETCH is re-entered.
- FSM states: IDLE, FETCH, ISSUE. All outputs are decoded from registered state/pc; nothing is combinational from inputs.
- IDLE: entered only from reset. Moves to FETCH on the first clock edge after rst deasserts.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - imem_ack=1 -> ISSUE on the next edge; otherwise remain in FETCH (no timeout).
- ISSUE:
  - instr_valid=1, imem_req=0.
  - stall=1: remain in ISSUE; pc held; PCSrc and jump ignored.
  - stall=0: choose the next pc by priority, then go to FETCH:
    - PCSrc=1 -> branch_target.
    - else jump=1 -> jump_target.
    - else pc_plus4.
- Simultaneous PCSrc=1 and jump=1: the branch wins; jump_target is discarded.
- Target alignment: bits [1:0] of the selected target are forced to 0 when loaded.
- Wrap: pc=0xFFFF_FFFC with no redirect -> next pc=0x0000_0000.
- flush:
  - Registered; asserted for exactly the one cycle after a redirect edge (ISSUE, stall=0, PCSrc|jump).
  - Never asserted for the sequential path.
- PCSrc, jump and the targets are don't-care outside ISSUE.
- Latency: minimum 2 cycles per instruction (ack in the first FETCH cycle, then ISSUE). Each extra cycle of ack delay or stall adds 1 cycle.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds three outputs, all reset to 0, each saturating at 0xFFFF_FFFF (no wrap):
  - instr_cnt[31:0]: increments on every ISSUE exit (stall=0).
  - taken_cnt[31:0]: increments on exits with PCSrc=1.
  - jump_cnt[31:0]: increments on exits with jump=1 and PCSrc=0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset/sequential: RESET_PC=0x100, rst pulse, imem_ack returned 1 cycle after every imem_req -> imem_addr sequence 0x100, 0x104, 0x108; instr_valid high 1 cycle per instruction; flush stays 0.
- Branch vs jump: in ISSUE at pc=0x200, PCSrc=1 with branch_target=0x403, jump=1 with jump_target=0x800 -> next imem_addr=0x400; flush=1 for exactly 1 cycle.
- Stall: hold stall=1 for 3 cycles in ISSUE while toggling PCSrc -> pc, instr_valid=1 and imem_req=0 unchanged. Release with PCSrc=0 -> next fetch at pc+4.
- Ack delay/wrap: pc=0xFFFF_FFFC, delay imem_ack 4 cycles -> imem_req and imem_addr held stable for all 4 cycles; following fetch address is 0x0000_0000.
- Reset mid-fetch: assert rst during FETCH at pc=0x300 -> imem_req=0 in the same cycle. After release: IDLE for 1 cycle, then fetch at RESET_PC; a stale ack during IDLE is ignored.
- BRANCH_STATS_EN: 5 instructions containing 2 taken branches and 1 jump -> instr_cnt=5, taken_cnt=2, jump_cnt=1. Preload near saturation -> counters hold at 0xFFFF_FFFF.
